// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch / issue stage sitting between instruction decode and execute.
// Decoded register fields arrive through a valid/ready handshake. The stage
// drives the register file read addresses combinationally and registers the
// returned operands toward execute. A 32-entry scoreboard marks registers
// with a pending writeback. Decode is stalled on RAW hazards (a source is
// pending) and WAW hazards (the destination is pending) until the writeback
// port retires the producer.
//
// Optional feature macro: OF_WB_BYPASS_EN
//   defined   : a writeback landing in the same cycle resolves the hazard.
//               The operand is forwarded from wb_wdata.
//   undefined : any pending source or destination stalls. Operands always
//               come from the register file.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      decode handshake (in_ready is independent of
//                            in_valid)
//   in_pc                    instruction PC, passed through to execute
//   in_rs, in_rt             source register numbers
//   in_dst, in_dst_en        destination register and its write enable
//   rf_raddr1, rf_raddr2     register file read addresses (= in_rs / in_rt)
//   rf_rdata1, rf_rdata2     register file asynchronous read data
//   wb_wen, wb_waddr,
//   wb_wdata                 writeback port (same as the register file write)
//   out_valid / out_ready    execute-side handshake
//   out_pc, out_src1,
//   out_src2, out_dst,
//   out_dst_en               registered instruction toward execute
//   sb_busy                  scoreboard; bit n set = register n pending
// -----------------------------------------------------------------------------
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_dst,
    input  logic        in_dst_en,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [4:0]  out_dst,
    output logic        out_dst_en,
    output logic [31:0] sb_busy
);

    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic        out_valid_reg;
    logic [31:0] out_pc_reg;
    logic [31:0] out_src1_reg;
    logic [31:0] out_src2_reg;
    logic [4:0]  out_dst_reg;
    logic        out_dst_en_reg;

    logic        rs_nz;
    logic        rt_nz;
    logic        dst_nz;
    logic        byp_rs;     // source 1 is resolved by this cycle's writeback
    logic        byp_rt;     // source 2 is resolved by this cycle's writeback
    logic        byp_dst;    // pending destination retires this cycle
    logic        hazard;
    logic        issue;
    logic [31:0] src1_val;
    logic [31:0] src2_val;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    assign rs_nz  = (in_rs  != 5'd0);
    assign rt_nz  = (in_rt  != 5'd0);
    assign dst_nz = (in_dst != 5'd0);

`ifdef OF_WB_BYPASS_EN
    // Register n is non-zero here whenever the comparison matches a
    // non-zero source, so a writeback to r0 never forwards.
    assign byp_rs  = busy_reg[in_rs]  && wb_wen && (wb_waddr == in_rs);
    assign byp_rt  = busy_reg[in_rt]  && wb_wen && (wb_waddr == in_rt);
    assign byp_dst = busy_reg[in_dst] && wb_wen && (wb_waddr == in_dst);
`else
    logic unused_wb_wdata;
    assign unused_wb_wdata = ^wb_wdata;
    assign byp_rs  = 1'b0;
    assign byp_rt  = 1'b0;
    assign byp_dst = 1'b0;
`endif

    // Sources are checked even if the instruction ignores them; r0 never
    // hazards because bit 0 of the scoreboard is never set.
    assign hazard = (rs_nz && busy_reg[in_rs] && !byp_rs)
                 || (rt_nz && busy_reg[in_rt] && !byp_rt)
                 || (in_dst_en && dst_nz && busy_reg[in_dst] && !byp_dst);

    // in_valid is deliberately kept out of in_ready.
    assign in_ready = !hazard && (!out_valid_reg || out_ready);
    assign issue    = in_valid && in_ready;

`ifdef OF_WB_BYPASS_EN
    assign src1_val = !rs_nz ? 32'd0 : (byp_rs ? wb_wdata : rf_rdata1);
    assign src2_val = !rt_nz ? 32'd0 : (byp_rt ? wb_wdata : rf_rdata2);
`else
    assign src1_val = !rs_nz ? 32'd0 : rf_rdata1;
    assign src2_val = !rt_nz ? 32'd0 : rf_rdata2;
`endif

    // Scoreboard next state. A set from a new issue beats a clear from a
    // retiring writeback to the same register: the new producer owns it.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue && in_dst_en && (in_dst == 5'(gi));
            assign clr_bit = wb_wen && (wb_waddr == 5'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate
    assign busy_next[0] = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg       <= 32'd0;
            out_valid_reg  <= 1'b0;
            out_pc_reg     <= 32'd0;
            out_src1_reg   <= 32'd0;
            out_src2_reg   <= 32'd0;
            out_dst_reg    <= 5'd0;
            out_dst_en_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            if (issue) begin
                out_valid_reg  <= 1'b1;
                out_pc_reg     <= in_pc;
                out_src1_reg   <= src1_val;
                out_src2_reg   <= src2_val;
                out_dst_reg    <= in_dst;
                out_dst_en_reg <= in_dst_en;
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_pc     = out_pc_reg;
    assign out_src1   = out_src1_reg;
    assign out_src2   = out_src2_reg;
    assign out_dst    = out_dst_reg;
    assign out_dst_en = out_dst_en_reg;
    assign sb_busy    = busy_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//
// Table-driven bench for operand_fetch. Each table row holds one cycle of
// stimulus, the expected combinational in_ready for that cycle, and the
// expected registered outputs after the following rising edge. Back-pressure
// and reset-while-busy are exercised as hand-written sequences afterwards.
// Expectations follow whichever OF_WB_BYPASS_EN build is compiled.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs, in_rt, in_dst;
    logic        in_dst_en;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_src1, out_src2;
    logic [4:0]  out_dst;
    logic        out_dst_en;
    logic [31:0] sb_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_dst     (in_dst),
        .in_dst_en  (in_dst_en),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_src1   (out_src1),
        .out_src2   (out_src2),
        .out_dst    (out_dst),
        .out_dst_en (out_dst_en),
        .sb_busy    (sb_busy)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  rs, rt, dst;
        logic        den;
        logic [31:0] rd1, rd2;
        logic        ordy;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        x_rdy;
        logic        x_ov;
        logic [31:0] x_pc, x_s1, x_s2;
        logic [4:0]  x_dst;
        logic        x_den;
        logic [31:0] x_busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [31:0] pc,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic den,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic ordy, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic x_rdy, input logic x_ov,
                       input logic [31:0] x_pc, input logic [31:0] x_s1,
                       input logic [31:0] x_s2, input logic [4:0] x_dst,
                       input logic x_den, input logic [31:0] x_busy);
        vec_t v;
        v.vld = vld;  v.pc = pc;  v.rs = rs;  v.rt = rt;  v.dst = dst;
        v.den = den;  v.rd1 = rd1; v.rd2 = rd2; v.ordy = ordy;
        v.wen = wen;  v.wa = wa;  v.wd = wd;
        v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_pc = x_pc; v.x_s1 = x_s1;
        v.x_s2 = x_s2; v.x_dst = x_dst; v.x_den = x_den; v.x_busy = x_busy;
        vq.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic den,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic ordy, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd);
        in_valid = vld; in_pc = pc; in_rs = rs; in_rt = rt; in_dst = dst;
        in_dst_en = den; rf_rdata1 = rd1; rf_rdata2 = rd2; out_ready = ordy;
        wb_wen = wen; wb_waddr = wa; wb_wdata = wd;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [31:0] pc,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [4:0] dst, input logic den,
                           input logic [31:0] busy);
        chk({tag, " out_valid"},  32'(out_valid),  32'(ov));
        chk({tag, " out_pc"},     out_pc,          pc);
        chk({tag, " out_src1"},   out_src1,        s1);
        chk({tag, " out_src2"},   out_src2,        s2);
        chk({tag, " out_dst"},    32'(out_dst),    32'(dst));
        chk({tag, " out_dst_en"}, 32'(out_dst_en), 32'(den));
        chk({tag, " sb_busy"},    sb_busy,         busy);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        rst = 1'b0;
        drive(v.vld, v.pc, v.rs, v.rt, v.dst, v.den, v.rd1, v.rd2,
              v.ordy, v.wen, v.wa, v.wd);
        #1;
        chk({tag, " in_ready"},  32'(in_ready),  32'(v.x_rdy));
        chk({tag, " rf_raddr1"}, 32'(rf_raddr1), 32'(v.rs));
        chk({tag, " rf_raddr2"}, 32'(rf_raddr2), 32'(v.rt));
        @(posedge clk);
        #1;
        chk_out(tag, v.x_ov, v.x_pc, v.x_s1, v.x_s2, v.x_dst, v.x_den, v.x_busy);
        $display("%s: vld=%0b pc=%08h rs=%0d rt=%0d dst=%0d/%0b wb=%0b:%0d -> ov=%0b pc=%08h s1=%08h s2=%08h busy=%08h",
                 tag, v.vld, v.pc, v.rs, v.rt, v.dst, v.den, v.wen, v.wa,
                 out_valid, out_pc, out_src1, out_src2, sb_busy);
    endtask

    initial begin
        // ---------------- reset then idle ----------------
        rst = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sb_busy",   sb_busy,        32'd0);
        chk("reset out_pc",    out_pc,         32'd0);
        $display("reset: in_ready=%0b out_valid=%0b sb_busy=%08h", in_ready, out_valid, sb_busy);

        // ---------------- vector table ----------------
        //   vld pc rs rt dst den rd1 rd2 ordy wen wa wd | rdy ov pc s1 s2 dst den busy
        // back-to-back independent instructions
        add(1, 32'h100, 1, 2, 3, 1, 32'h11, 32'h22, 1, 0, 0, 0,     1, 1, 32'h100, 32'h11, 32'h22, 3, 1, 32'h08);
        add(1, 32'h104, 4, 5, 6, 1, 32'h44, 32'h55, 1, 0, 0, 0,     1, 1, 32'h104, 32'h44, 32'h55, 6, 1, 32'h48);
        // retire both producers; outputs other than out_valid hold
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h33,           1, 0, 32'h104, 32'h44, 32'h55, 6, 1, 32'h40);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 32'h66,           1, 0, 32'h104, 32'h44, 32'h55, 6, 1, 32'h00);
        // r0 handling: dst=0 never marks busy, source 0 reads as 0
        add(1, 32'h200, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0,
                                                                   1, 1, 32'h200, 32'h0, 32'h0, 0, 1, 32'h00);
        add(1, 32'h204, 0, 9, 10, 0, 32'hFFFFFFFF, 32'h99, 1, 0, 0, 0,
                                                                   1, 1, 32'h204, 32'h0, 32'h99, 10, 0, 32'h00);
        // writeback to r0 is ignored
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1234,         1, 0, 32'h204, 32'h0, 32'h99, 10, 0, 32'h00);
        // producer of r3, then WAW and RAW stalls
        add(1, 32'h300, 1, 2, 3, 1, 32'h1, 32'h2, 1, 0, 0, 0,       1, 1, 32'h300, 32'h1, 32'h2, 3, 1, 32'h08);
        add(1, 32'h304, 0, 0, 3, 1, 32'h5, 32'h6, 1, 0, 0, 0,       0, 0, 32'h300, 32'h1, 32'h2, 3, 1, 32'h08);
        add(1, 32'h308, 3, 0, 0, 0, 32'hBAD, 32'h7, 1, 0, 0, 0,     0, 0, 32'h300, 32'h1, 32'h2, 3, 1, 32'h08);
`ifdef OF_WB_BYPASS_EN
        // cycle W: consumer issues with the forwarded value
        add(1, 32'h308, 3, 0, 0, 0, 32'hBAD, 32'h7, 1, 1, 3, 32'hDEADBEEF,
                                                                   1, 1, 32'h308, 32'hDEADBEEF, 32'h0, 0, 0, 32'h00);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,                1, 0, 32'h308, 32'hDEADBEEF, 32'h0, 0, 0, 32'h00);
`else
        // cycle W: still stalled; W+1: issues reading the written register
        add(1, 32'h308, 3, 0, 0, 0, 32'hBAD, 32'h7, 1, 1, 3, 32'hDEADBEEF,
                                                                   0, 0, 32'h300, 32'h1, 32'h2, 3, 1, 32'h00);
        add(1, 32'h308, 3, 0, 0, 0, 32'hDEADBEEF, 32'h7, 1, 0, 0, 0,
                                                                   1, 1, 32'h308, 32'hDEADBEEF, 32'h0, 0, 0, 32'h00);
`endif
        // WAW against a same-cycle retire of the same register
        add(1, 32'h400, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0,               1, 1, 32'h400, 32'h0, 32'h0, 3, 1, 32'h08);
`ifdef OF_WB_BYPASS_EN
        // issue and retire of r3 together: the new producer keeps it busy
        add(1, 32'h404, 0, 0, 3, 1, 0, 0, 1, 1, 3, 32'h77,          1, 1, 32'h404, 32'h0, 32'h0, 3, 1, 32'h08);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h78,           1, 0, 32'h404, 32'h0, 32'h0, 3, 1, 32'h00);
`else
        add(1, 32'h404, 0, 0, 3, 1, 0, 0, 1, 1, 3, 32'h77,          0, 0, 32'h400, 32'h0, 32'h0, 3, 1, 32'h00);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h78,           1, 0, 32'h400, 32'h0, 32'h0, 3, 1, 32'h00);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], i);
        end

        // ---------------- back-pressure ----------------
        @(negedge clk);
        drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd7, 1'b1, 32'hA, 32'hB, 1'b1, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk_out("bp load", 1'b1, 32'h500, 32'hA, 32'hB, 5'd7, 1'b1, 32'h80);
        $display("bp load: ov=%0b pc=%08h busy=%08h", out_valid, out_pc, sb_busy);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h504, 5'd4, 5'd5, 5'd8, 1'b1, 32'hC, 32'hD, 1'b0, 1'b0, 5'd0, 32'd0);
            #1;
            chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk_out($sformatf("bp%0d", k), 1'b1, 32'h500, 32'hA, 32'hB, 5'd7, 1'b1, 32'h80);
            $display("bp hold %0d: in_ready=0 expected, ov=%0b pc=%08h busy=%08h", k, out_valid, out_pc, sb_busy);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp resume in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_out("bp resume", 1'b1, 32'h504, 32'hC, 32'hD, 5'd8, 1'b1, 32'h180);
        $display("bp resume: ov=%0b pc=%08h busy=%08h", out_valid, out_pc, sb_busy);

        // ---------------- reset mid-flight ----------------
        @(negedge clk);
        drive(1'b1, 32'h508, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk_out("mid load", 1'b1, 32'h508, 32'h0, 32'h0, 5'd3, 1'b1, 32'h188);
        $display("mid load: ov=%0b busy=%08h", out_valid, sb_busy);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h50C, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h1);
        @(posedge clk); #1;
        chk_out("mid reset", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        $display("mid reset: ov=%0b pc=%08h busy=%08h", out_valid, out_pc, sb_busy);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd3, 5'd7, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("post reset in_ready", 32'(in_ready), 32'd1);
        $display("post reset: in_ready=%0b", in_ready);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
